// File: rtl/control_unit.sv
// Multi-cycle LEGv8-subset control unit: sequences FETCH/DECODE/EXEC(/CBTEST)
// and drives the datapath control word from the FSM state, IR and status flags.
module control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IR,
    input  logic [3:0]  SF,
    output logic        AS,
    output logic [1:0]  DS,
    output logic [1:0]  PS,
    output logic        PC_Sel,
    output logic        K_Sel,
    output logic        IL,
    output logic        SL,
    output logic        MW,
    output logic        RW,
    output logic [4:0]  FS,
    output logic        C0,
    output logic [4:0]  DA,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic [63:0] K,
    output logic        illegal,
    output logic [1:0]  state_o
);

    localparam logic [4:0] FS_ADD   = 5'b00100;
    localparam logic [4:0] FS_SUB   = 5'b01001;
    localparam logic [4:0] FS_AND   = 5'b00000;
    localparam logic [4:0] FS_OR    = 5'b00001;
    localparam logic [4:0] FS_XOR   = 5'b00010;
    localparam logic [4:0] FS_PASSB = 5'b01100;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_REL  = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_CBTEST = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic [10:0] op11;
    logic [9:0]  op10;
    logic [7:0]  op8;
    logic [5:0]  op6;
    logic [63:0] k_imm, k_mem, k_br, k_cond;
    logic        flag_z, flag_n, flag_c, flag_v;
    logic        cond_true;

    assign op11 = IR[31:21];
    assign op10 = IR[31:22];
    assign op8  = IR[31:24];
    assign op6  = IR[31:26];

    // Branch constants are byte offsets from the instruction address.
    assign k_imm  = {52'd0, IR[21:10]};
    assign k_mem  = {{55{IR[20]}}, IR[20:12]};
    assign k_br   = {{36{IR[25]}}, IR[25:0], 2'b00};
    assign k_cond = {{43{IR[23]}}, IR[23:5], 2'b00};

    assign flag_z = SF[0];
    assign flag_n = SF[1];
    assign flag_c = SF[2];
    assign flag_v = SF[3];

    always_comb begin
        cond_true = 1'b1;
        case (IR[3:0])
            4'd0:    cond_true = flag_z;
            4'd1:    cond_true = !flag_z;
            4'd2:    cond_true = flag_c;
            4'd3:    cond_true = !flag_c;
            4'd4:    cond_true = flag_n;
            4'd5:    cond_true = !flag_n;
            4'd6:    cond_true = flag_v;
            4'd7:    cond_true = !flag_v;
            4'd8:    cond_true = flag_c & !flag_z;
            4'd9:    cond_true = !(flag_c & !flag_z);
            4'd10:   cond_true = (flag_n == flag_v);
            4'd11:   cond_true = (flag_n != flag_v);
            4'd12:   cond_true = !flag_z & (flag_n == flag_v);
            4'd13:   cond_true = !(!flag_z & (flag_n == flag_v));
            default: cond_true = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

    always_comb begin
        state_d = state_q;
        AS      = 1'b1;
        DS      = 2'b00;
        PS      = PS_HOLD;
        PC_Sel  = 1'b0;
        K_Sel   = 1'b0;
        IL      = 1'b0;
        SL      = 1'b0;
        MW      = 1'b0;
        RW      = 1'b0;
        FS      = FS_ADD;
        C0      = 1'b0;
        SA      = IR[9:5];
        SB      = IR[20:16];
        DA      = IR[4:0];
        K       = 64'd0;
        illegal = 1'b0;

        case (state_q)
            ST_FETCH: begin
                AS      = 1'b1;
                DS      = 2'b11;
                IL      = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                PS      = PS_INC;
                // Longest opcode field is tried first; shorter ones only on a miss.
                case (op11)
                    11'b10001011000: begin RW = 1'b1; FS = FS_ADD; end
                    11'b11001011000: begin RW = 1'b1; FS = FS_SUB; C0 = 1'b1; end
                    11'b10001010000: begin RW = 1'b1; FS = FS_AND; end
                    11'b10101010000: begin RW = 1'b1; FS = FS_OR;  end
                    11'b11001010000: begin RW = 1'b1; FS = FS_XOR; end
                    11'b10101011000: begin RW = 1'b1; FS = FS_ADD; SL = 1'b1; end
                    11'b11101011000: begin RW = 1'b1; FS = FS_SUB; C0 = 1'b1; SL = 1'b1; end
                    11'b11111000010: begin
                        K     = k_mem;
                        K_Sel = 1'b1;
                        AS    = 1'b0;
                        DS    = 2'b11;
                        RW    = 1'b1;
                    end
                    11'b11111000000: begin
                        K     = k_mem;
                        K_Sel = 1'b1;
                        AS    = 1'b0;
                        DS    = 2'b01;
                        SB    = IR[4:0];
                        MW    = 1'b1;
                    end
                    default: begin
                        case (op10)
                            10'b1001000100: begin
                                K = k_imm; K_Sel = 1'b1; RW = 1'b1;
                            end
                            10'b1101000100: begin
                                K = k_imm; K_Sel = 1'b1; RW = 1'b1; FS = FS_SUB; C0 = 1'b1;
                            end
                            default: begin
                                case (op8)
                                    8'b01010100: begin
                                        K      = k_cond;
                                        PC_Sel = 1'b1;
                                        PS     = cond_true ? PS_REL : PS_INC;
                                    end
                                    8'b10110100, 8'b10110101: begin
                                        // Pass the tested register through the ALU to refresh Z.
                                        SB      = IR[4:0];
                                        FS      = FS_PASSB;
                                        SL      = 1'b1;
                                        PS      = PS_HOLD;
                                        state_d = ST_CBTEST;
                                    end
                                    default: begin
                                        if (op6 == 6'b000101) begin
                                            K      = k_br;
                                            PC_Sel = 1'b1;
                                            PS     = PS_REL;
                                        end else begin
                                            illegal = 1'b1;
                                        end
                                    end
                                endcase
                            end
                        endcase
                    end
                endcase
            end
            ST_CBTEST: begin
                state_d = ST_FETCH;
                K       = k_cond;
                PC_Sel  = 1'b1;
                // IR[24] distinguishes CBNZ from CBZ.
                PS      = (flag_z ^ IR[24]) ? PS_REL : PS_INC;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (rst) begin
            state_d = ST_FETCH;
            IL      = 1'b0;
            SL      = 1'b0;
            MW      = 1'b0;
            RW      = 1'b0;
            illegal = 1'b0;
            PS      = PS_HOLD;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed test-plan sequences plus randomized
// instructions and flags checked against an instruction-level reference model.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IR;
    logic [3:0]  SF;
    logic        AS, PC_Sel, K_Sel, IL, SL, MW, RW, C0, illegal;
    logic [1:0]  DS, PS, state_o;
    logic [4:0]  FS, DA, SA, SB;
    logic [63:0] K;

    int checks = 0;
    int errors = 0;
    int phase;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .rst(rst), .IR(IR), .SF(SF),
        .AS(AS), .DS(DS), .PS(PS), .PC_Sel(PC_Sel), .K_Sel(K_Sel),
        .IL(IL), .SL(SL), .MW(MW), .RW(RW), .FS(FS), .C0(C0),
        .DA(DA), .SA(SA), .SB(SB), .K(K), .illegal(illegal), .state_o(state_o)
    );

    typedef struct packed {
        logic        asel;
        logic [1:0]  dsel;
        logic [1:0]  pfun;
        logic        pcsel;
        logic        ksel;
        logic        il;
        logic        sl;
        logic        mw;
        logic        rw;
        logic [4:0]  fs;
        logic        c0;
        logic [4:0]  da;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [63:0] k;
        logic        ill;
    } ctrl_t;

    typedef enum {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDS, OP_SUBS, OP_LDUR,
                  OP_STUR, OP_ADDI, OP_SUBI, OP_BCOND, OP_CBZ, OP_CBNZ, OP_B, OP_ILL} op_e;

    int          tbl_len[15];
    int unsigned tbl_pat[15];
    op_e         tbl_op[15];
    int          tbl_n = 0;

    function automatic void add_op(input int len, input int unsigned pat, input op_e op);
        tbl_len[tbl_n] = len;
        tbl_pat[tbl_n] = pat;
        tbl_op[tbl_n]  = op;
        tbl_n++;
    endfunction

    // Ordered longest prefix first so the first hit is the architectural decode.
    function automatic void init_table();
        add_op(11, 11'b10001011000, OP_ADD);
        add_op(11, 11'b11001011000, OP_SUB);
        add_op(11, 11'b10001010000, OP_AND);
        add_op(11, 11'b10101010000, OP_ORR);
        add_op(11, 11'b11001010000, OP_EOR);
        add_op(11, 11'b10101011000, OP_ADDS);
        add_op(11, 11'b11101011000, OP_SUBS);
        add_op(11, 11'b11111000010, OP_LDUR);
        add_op(11, 11'b11111000000, OP_STUR);
        add_op(10, 10'b1001000100,  OP_ADDI);
        add_op(10, 10'b1101000100,  OP_SUBI);
        add_op(8,  8'b01010100,     OP_BCOND);
        add_op(8,  8'b10110100,     OP_CBZ);
        add_op(8,  8'b10110101,     OP_CBNZ);
        add_op(6,  6'b000101,       OP_B);
    endfunction

    function automatic op_e classify(input logic [31:0] ir);
        for (int i = 0; i < tbl_n; i++) begin
            if ((ir >> (32 - tbl_len[i])) == tbl_pat[i]) return tbl_op[i];
        end
        return OP_ILL;
    endfunction

    function automatic bit is_cb(input logic [31:0] ir);
        op_e op = classify(ir);
        return (op == OP_CBZ) || (op == OP_CBNZ);
    endfunction

    function automatic longint sext(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    function automatic bit cond_holds(input logic [3:0] cond, input logic [3:0] sf);
        bit z = sf[0], n = sf[1], c = sf[2], v = sf[3];
        bit base;
        case (cond >> 1)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        // Odd codes negate their even partner, except 15 which is "always".
        return (cond[0] && cond != 4'd15) ? !base : base;
    endfunction

    // phase: 0 fetch, 1 decode, 2 execute, 3 compare-and-branch resolve
    function automatic ctrl_t model(input int ph, input logic [31:0] ir,
                                    input logic [3:0] sf, input bit r);
        ctrl_t c;
        op_e   op;
        c      = '0;
        c.asel = 1'b1;
        c.fs   = 5'b00100;
        c.sa   = ir[9:5];
        c.sb   = ir[20:16];
        c.da   = ir[4:0];
        if (ph == 0) begin
            c.dsel = 2'b11;
            c.il   = 1'b1;
        end else if (ph == 2) begin
            op     = classify(ir);
            c.pfun = 2'b01;
            case (op)
                OP_ADD:  c.rw = 1;
                OP_ADDS: begin c.rw = 1; c.sl = 1; end
                OP_SUB:  begin c.rw = 1; c.fs = 5'b01001; c.c0 = 1; end
                OP_SUBS: begin c.rw = 1; c.fs = 5'b01001; c.c0 = 1; c.sl = 1; end
                OP_AND:  begin c.rw = 1; c.fs = 5'b00000; end
                OP_ORR:  begin c.rw = 1; c.fs = 5'b00001; end
                OP_EOR:  begin c.rw = 1; c.fs = 5'b00010; end
                OP_ADDI: begin c.rw = 1; c.ksel = 1; c.k = 64'(ir[21:10]); end
                OP_SUBI: begin
                    c.rw = 1; c.ksel = 1; c.k = 64'(ir[21:10]); c.fs = 5'b01001; c.c0 = 1;
                end
                OP_LDUR: begin
                    c.k = sext(longint'(ir[20:12]), 9); c.ksel = 1;
                    c.asel = 0; c.dsel = 2'b11; c.rw = 1;
                end
                OP_STUR: begin
                    c.k = sext(longint'(ir[20:12]), 9); c.ksel = 1;
                    c.asel = 0; c.dsel = 2'b01; c.sb = ir[4:0]; c.mw = 1;
                end
                OP_B: begin
                    c.k = sext(longint'(ir[25:0]), 26) * 4; c.pcsel = 1; c.pfun = 2'b11;
                end
                OP_BCOND: begin
                    c.k = sext(longint'(ir[23:5]), 19) * 4; c.pcsel = 1;
                    c.pfun = cond_holds(ir[3:0], sf) ? 2'b11 : 2'b01;
                end
                OP_CBZ, OP_CBNZ: begin
                    c.sb = ir[4:0]; c.fs = 5'b01100; c.sl = 1; c.pfun = 2'b00;
                end
                default: c.ill = 1;
            endcase
        end else if (ph == 3) begin
            c.k     = sext(longint'(ir[23:5]), 19) * 4;
            c.pcsel = 1;
            if (classify(ir) == OP_CBZ) c.pfun = sf[0] ? 2'b11 : 2'b01;
            else                        c.pfun = sf[0] ? 2'b01 : 2'b11;
        end
        if (r) begin
            c.il = 0; c.sl = 0; c.mw = 0; c.rw = 0; c.ill = 0; c.pfun = 2'b00;
        end
        return c;
    endfunction

    function automatic ctrl_t sample();
        ctrl_t s;
        s = '{asel: AS, dsel: DS, pfun: PS, pcsel: PC_Sel, ksel: K_Sel, il: IL, sl: SL,
              mw: MW, rw: RW, fs: FS, c0: C0, da: DA, sa: SA, sb: SB, k: K, ill: illegal};
        return s;
    endfunction

    function automatic logic [31:0] gen_instr();
        int          pick = $urandom_range(0, 17);
        logic [31:0] ir   = $urandom;
        if (pick < tbl_n) begin
            ir = (tbl_pat[pick] << (32 - tbl_len[pick])) |
                 (ir & ((32'd1 << (32 - tbl_len[pick])) - 32'd1));
        end
        return ir;
    endfunction

    task automatic drive(input logic [31:0] ir, input logic [3:0] sf, input logic r);
        IR  = ir;
        SF  = sf;
        rst = r;
        @(negedge clk);
    endtask

    task automatic advance(input logic r, input bit cb);
        @(posedge clk);
        #1;
        if (r) phase = 0;
        else begin
            case (phase)
                0: phase = 1;
                1: phase = 2;
                2: phase = cb ? 3 : 0;
                default: phase = 0;
            endcase
        end
    endtask

    task automatic test_reset();
        ctrl_t got, exp;
        for (int i = 0; i < 3; i++) begin
            drive(32'h8B020023, 4'($urandom), 1'b1);
            got = sample();
            exp = model(phase, IR, SF, 1'b1);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_hold got=%h exp=%h", got, exp);
            end
            advance(1'b1, 1'b0);
        end
    endtask

    task automatic test_directed();
        logic [31:0] d_ir[10]  = '{32'h8B020023, 32'h91001401, 32'hEB020023, 32'hF8408022,
                                   32'hF81F8022, 32'h54000081, 32'h54000081, 32'hB4FFFFC5,
                                   32'hB4FFFFC5, 32'h00000000};
        logic [3:0]  d_sf[10]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0};
        logic [63:0] d_k[10]   = '{64'd0, 64'd5, 64'd0, 64'd8, 64'hFFFF_FFFF_FFFF_FFF8, 64'd16,
                                   64'd16, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0};
        logic [1:0]  d_ps[10]  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11,
                                   2'b01, 2'b01};
        logic        d_ill[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        ctrl_t got, exp;
        bit    cb, last;
        for (int i = 0; i < 10; i++) begin
            cb = is_cb(d_ir[i]);
            for (int c = 0; c < 6; c++) begin
                drive(d_ir[i], d_sf[i], 1'b0);
                got  = sample();
                exp  = model(phase, IR, SF, 1'b0);
                last = (phase == 3) || (phase == 2 && !cb);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL directed_%0d ph=%0d got=%h exp=%h", i, phase, got, exp);
                end
                if (last) begin
                    checks++;
                    if (K !== d_k[i] || PS !== d_ps[i] || illegal !== d_ill[i]) begin
                        errors++;
                        $display("FAIL directed_lit_%0d K=%h PS=%b ill=%b need K=%h PS=%b ill=%b",
                                 i, K, PS, illegal, d_k[i], d_ps[i], d_ill[i]);
                    end
                end
                advance(1'b0, cb);
                if (phase == 0) break;
            end
        end
    endtask

    task automatic test_bcond();
        ctrl_t       got, exp;
        logic [31:0] ir;
        for (int cond = 0; cond < 16; cond++) begin
            for (int rep = 0; rep < 3; rep++) begin
                ir = {8'h54, 19'($urandom), 1'($urandom), 4'(cond)};
                for (int c = 0; c < 3; c++) begin
                    drive(ir, 4'($urandom), 1'b0);
                    got = sample();
                    exp = model(phase, IR, SF, 1'b0);
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL bcond_%0d ph=%0d sf=%b got=%h exp=%h", cond, phase, SF, got, exp);
                    end
                    advance(1'b0, 1'b0);
                end
            end
        end
    endtask

    task automatic test_cb();
        ctrl_t       got, exp;
        logic [31:0] ir;
        for (int n = 0; n < 12; n++) begin
            ir = {7'b1011010, 1'($urandom), 24'($urandom)};
            for (int c = 0; c < 6; c++) begin
                drive(ir, 4'($urandom), 1'b0);
                got = sample();
                exp = model(phase, IR, SF, 1'b0);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL cb ph=%0d ir=%h sf=%b got=%h exp=%h", phase, IR, SF, got, exp);
                end
                advance(1'b0, 1'b1);
                if (phase == 0) break;
            end
            if (phase != 0) begin
                errors++;
                $display("FAIL cb_seq_len phase=%0d need 0", phase);
            end
        end
    endtask

    task automatic test_reset_mid();
        ctrl_t       got, exp;
        logic [31:0] ir;
        for (int t = 0; t < 4; t++) begin
            ir = {7'b1011010, 1'($urandom), 24'($urandom)};
            for (int c = 0; c < 8 && phase != t; c++) begin
                drive(ir, 4'($urandom), 1'b0);
                advance(1'b0, 1'b1);
            end
            drive(ir, 4'($urandom), 1'b1);
            got = sample();
            exp = model(t, IR, SF, 1'b1);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_in_phase_%0d got=%h exp=%h", t, got, exp);
            end
            advance(1'b1, 1'b1);
            drive(ir, 4'($urandom), 1'b0);
            got = sample();
            exp = model(0, IR, SF, 1'b0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL after_reset_%0d got=%h exp=%h", t, got, exp);
            end
            advance(1'b0, 1'b1);
            drive(ir, SF, 1'b1);
            advance(1'b1, 1'b1);
        end
    endtask

    task automatic test_random();
        ctrl_t       got, exp;
        logic [31:0] ir;
        bit          cb;
        for (int n = 0; n < 250; n++) begin
            ir = gen_instr();
            cb = is_cb(ir);
            for (int c = 0; c < 6; c++) begin
                drive(ir, 4'($urandom), 1'b0);
                got = sample();
                exp = model(phase, IR, SF, 1'b0);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random ph=%0d ir=%h sf=%b got=%h exp=%h", phase, IR, SF, got, exp);
                end
                advance(1'b0, cb);
                if (phase == 0) break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        init_table();
        rst = 1'b1;
        IR  = 32'd0;
        SF  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        phase = 0;
        test_reset();
        test_directed();
        test_bcond();
        test_cb();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
